// File: rtl/rr_arbiter_8_pkg.sv
// rr_arbiter_8_pkg
//   Shared definitions for the 8-requester round-robin arbiter:
//   requester count and index width, the FSM state encoding, and the
//   rotating-priority search helpers used by the arbiter core.
package rr_arbiter_8_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Rotating-priority search. The scan starts one slot past last_idx,
  // ascends and wraps 7->0. The index arithmetic deliberately overflows
  // at IDX_W bits to get the modulo-8 rotation for free. The final step
  // (i == N_REQ) lands back on last_idx, so a lone requester that owned
  // the previous grant can still win. Returns a one-hot vector, or zero.
  function automatic logic [N_REQ-1:0] next_rr_winner(
    input logic [N_REQ-1:0] vec,
    input logic [IDX_W-1:0] last_idx
  );
    logic [N_REQ-1:0] result;
    logic [IDX_W-1:0] idx;
    logic             found;
    result = '0;
    found  = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = last_idx + IDX_W'(i);
      if (!found && vec[idx]) begin
        result[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    return result;
  endfunction

  // Index of a one-hot vector. Used only on next_rr_winner's output, which
  // is guaranteed one-hot or zero, so OR-ing the indices is exact.
  function automatic logic [IDX_W-1:0] onehot_to_idx(
    input logic [N_REQ-1:0] vec
  );
    logic [IDX_W-1:0] result;
    result = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) begin
        result = result | IDX_W'(i);
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/encoder_8_2_3.sv
// encoder_8_2_3
//   8-to-3 one-hot encoder. Purely combinational.
//   Ports:
//     onehot  in  8  one-hot (or all-zero) vector
//     idx     out 3  index of the set bit; 3'b000 when onehot is zero
//   Each output bit is the OR of the input bits whose position has that
//   bit set. This is exact only for one-hot input, which is what the
//   arbiter guarantees.
module encoder_8_2_3
  import rr_arbiter_8_pkg::*;
(
  input  logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0][N_REQ-1:0] sel;

  genvar gi, gj;
  generate
    for (gi = 0; gi < IDX_W; gi++) begin : g_bit
      for (gj = 0; gj < N_REQ; gj++) begin : g_src
        if (((gj >> gi) & 1) != 0) begin : g_on
          assign sel[gi][gj] = onehot[gj];
        end else begin : g_off
          assign sel[gi][gj] = 1'b0;
        end
      end
      assign idx[gi] = |sel[gi];
    end
  endgenerate

endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8
//   Round-robin arbiter sharing one resource among 8 requesters. The
//   grant is registered and one-hot. An owner keeps the grant until it
//   drops its request, or until HOLD_MAX consecutive cycles have elapsed.
//   Ownership then passes straight to the next requester in rotation,
//   with no idle bubble.
//   Parameters:
//     HOLD_MAX      max consecutive owned cycles (0 = unlimited, 0..255)
//   Ports:
//     clk           in   1  clock, rising edge
//     rst_n         in   1  asynchronous active-low reset
//     arb_en        in   1  allow new grants (current ownership unaffected)
//     req           in   8  level requests
//     gnt           out  8  registered one-hot grant, or zero
//     gnt_idx       out  3  encoded index of gnt (0 when gnt is zero)
//     gnt_valid     out  1  registered, gnt non-zero
//     hold_expired  out  1  pulse in the cycle after a forced withdrawal
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arb_en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             hold_expired
);

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
  localparam bit         LIMIT_ON = (HOLD_MAX != 0);
  // With no limit, the counter parks at its top value instead of wrapping.
  localparam logic [7:0] CNT_SAT  = LIMIT_ON ? HOLD_LIM : 8'hFF;

  state_t           state_reg, state_next;
  logic [N_REQ-1:0] gnt_reg, gnt_next;
  logic [IDX_W-1:0] last_idx_reg, last_idx_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic             gnt_valid_reg, gnt_valid_next;
  logic             hold_expired_reg, hold_expired_next;

  logic             owner_req;
  logic             timeout;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] winner;

  always_comb begin
    owner_req = |(req & gnt_reg);
    timeout   = LIMIT_ON && (state_reg == OWN) && owner_req &&
                (cnt_reg == HOLD_LIM);

    // arb_en gates only new grants. The owner's bit is masked on timeout,
    // so the handover can't hand the grant straight back to it. On release
    // its bit is already low in req.
    elig = arb_en ? req : '0;
    if (timeout) begin
      elig = elig & ~gnt_reg;
    end
    winner = next_rr_winner(elig, last_idx_reg);

    state_next        = state_reg;
    gnt_next          = gnt_reg;
    last_idx_next     = last_idx_reg;
    cnt_next          = cnt_reg;
    hold_expired_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|winner) begin
          state_next    = OWN;
          gnt_next      = winner;
          last_idx_next = onehot_to_idx(winner);
          cnt_next      = 8'd1;
        end
      end
      OWN: begin
        if (owner_req && !timeout) begin
          if (cnt_reg != CNT_SAT) begin
            cnt_next = cnt_reg + 8'd1;
          end
        end else begin
          // Release or forced withdrawal: re-arbitrate on this same edge.
          hold_expired_next = timeout;
          if (|winner) begin
            gnt_next      = winner;
            last_idx_next = onehot_to_idx(winner);
            cnt_next      = 8'd1;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
            cnt_next   = 8'd0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        cnt_next   = 8'd0;
      end
    endcase

    gnt_valid_next = (state_next == OWN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      gnt_reg          <= '0;
      last_idx_reg     <= 3'd7;  // requester 0 is first in line after reset
      cnt_reg          <= 8'd0;
      gnt_valid_reg    <= 1'b0;
      hold_expired_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      gnt_reg          <= gnt_next;
      last_idx_reg     <= last_idx_next;
      cnt_reg          <= cnt_next;
      gnt_valid_reg    <= gnt_valid_next;
      hold_expired_reg <= hold_expired_next;
    end
  end

  assign gnt          = gnt_reg;
  assign gnt_valid    = gnt_valid_reg;
  assign hold_expired = hold_expired_reg;

  encoder_8_2_3 u_enc (
    .onehot (gnt_reg),
    .idx    (gnt_idx)
  );

endmodule
